// File: rtl/mips_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
// Shared types and constants for the multicycle MIPS-compatible core.
//   state_t      : step encoding decoded by the combinational controller.
//   RESET_VECTOR : boot address loaded by the PC register on reset.
//   is_active()  : true for the steps in which the core is executing.
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

   // Encodings are fixed because the controller decodes them directly.
   // Values 5 and 6 are unused and treated as illegal by the sequencer.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC1  = 3'd3,
      ST_EXEC2  = 3'd4,
      ST_HALTED = 3'd7
   } state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   // Steps during which the core is running an instruction.
   function automatic logic is_active(input state_t st);
      return (st == ST_FETCH) || (st == ST_DECODE) ||
             (st == ST_EXEC1) || (st == ST_EXEC2);
   endfunction

endpackage

// File: rtl/mips_cpu_state_sequencer_if.sv
// -----------------------------------------------------------------------------
// mips_cpu_state_sequencer_if
// Bundle between the step sequencer and the rest of the core.
//   waitrequest  : memory not ready, hold the current access
//   mem_access   : controller asserts memread|memwrite in the current step
//   jump_to_zero : current instruction redirects the PC to 0 (valid in EXEC2)
//   state        : current step, to the controller
//   active       : core executing
//   retire       : one-cycle pulse after an instruction completes
//   cycle_count  : cycles spent active
//   instr_count  : instructions retired
// Modports: master = sequencer side, slave = controller/datapath side.
// -----------------------------------------------------------------------------
interface mips_cpu_state_sequencer_if
   import mips_cpu_pkg::*;
#(
   parameter int CNT_W = 32
);

   logic             waitrequest;
   logic             mem_access;
   logic             jump_to_zero;
   state_t           state;
   logic             active;
   logic             retire;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  waitrequest,
      input  mem_access,
      input  jump_to_zero,
      output state,
      output active,
      output retire,
      output cycle_count,
      output instr_count
   );

   modport slave (
      output waitrequest,
      output mem_access,
      output jump_to_zero,
      input  state,
      input  active,
      input  retire,
      input  cycle_count,
      input  instr_count
   );

endinterface

// File: rtl/mips_cpu_counter.sv
// -----------------------------------------------------------------------------
// mips_cpu_counter
// Free-running CNT_W-bit counter with enable and asynchronous active-low
// clear. Wraps modulo 2^CNT_W, no saturation.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear
//   en    : count this edge
//   count : current value
// -----------------------------------------------------------------------------
module mips_cpu_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/mips_cpu_state_sequencer.sv
// -----------------------------------------------------------------------------
// mips_cpu_state_sequencer
// Multicycle step sequencer: IDLE -> FETCH -> DECODE -> EXEC1 -> EXEC2 ->
// FETCH ..., stalling on memory wait-states and stopping in HALTED when an
// instruction jumps to address 0. Keeps cycle and retired-instruction counts.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : master side of mips_cpu_state_sequencer_if (see interface header)
// All outputs are registered; no combinational input-to-output path.
// -----------------------------------------------------------------------------
module mips_cpu_state_sequencer
   import mips_cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   mips_cpu_state_sequencer_if.master    bus
);

   state_t state_q;
   state_t state_d;
   logic   active_q;
   logic   active_d;
   logic   retire_q;
   logic   retire_d;
   logic   cyc_en;
   logic   ins_en;
   logic   mem_stall;

   // A memory-access step only stalls when the controller actually uses
   // memory in it; FETCH always reads, so it checks waitrequest alone.
   assign mem_stall = bus.mem_access && bus.waitrequest;

   always_comb begin
      state_d  = state_q;
      retire_d = 1'b0;
      ins_en   = 1'b0;
      cyc_en   = is_active(state_q);
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (!bus.waitrequest) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC1;
         end
         ST_EXEC1: begin
            if (!mem_stall) begin
               state_d = ST_EXEC2;
            end
         end
         ST_EXEC2: begin
            // jump_to_zero is only looked at on the exit edge, so a stall
            // defers its sampling until the memory access completes.
            if (!mem_stall) begin
               retire_d = 1'b1;
               ins_en   = 1'b1;
               state_d  = bus.jump_to_zero ? ST_HALTED : ST_FETCH;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            // Illegal encodings park the core; not active, so counters freeze.
            state_d = ST_HALTED;
         end
      endcase
      active_d = is_active(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         active_q <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         retire_q <= retire_d;
      end
   end

   mips_cpu_counter #(
      .CNT_W (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cyc_en),
      .count (bus.cycle_count)
   );

   mips_cpu_counter #(
      .CNT_W (CNT_W)
   ) u_instr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ins_en),
      .count (bus.instr_count)
   );

   assign bus.state  = state_q;
   assign bus.active = active_q;
   assign bus.retire = retire_q;

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_state_sequencer
// Directed scoreboard bench. Each stimulus step pushes the hand-computed
// outputs for the current cycle; a monitor pops and compares them at the
// falling edge. A second 4-bit-counter instance runs on the same inputs so
// counter wrap-around is observed within a short run.
// -----------------------------------------------------------------------------
module tb_mips_cpu_state_sequencer;
   import mips_cpu_pkg::*;

   typedef struct {
      logic [2:0]  st;
      logic        act;
      logic        ret;
      logic [31:0] cyc;
      logic [31:0] ins;
   } exp_t;

   logic clk;
   logic rst_n;

   exp_t q[$];
   int   n_vec;
   int   n_err;

   mips_cpu_state_sequencer_if #(.CNT_W(32)) bus ();
   mips_cpu_state_sequencer_if #(.CNT_W(4))  bus4 ();

   mips_cpu_state_sequencer #(.CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mips_cpu_state_sequencer #(.CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Monitor: one expected record per cycle, compared at the falling edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic bad;
         e = q.pop_front();
         n_vec = n_vec + 1;
         bad = (bus.state !== e.st) || (bus.active !== e.act) ||
               (bus.retire !== e.ret) || (bus.cycle_count !== e.cyc) ||
               (bus.instr_count !== e.ins) ||
               (bus4.state !== e.st) || (bus4.cycle_count !== e.cyc[3:0]) ||
               (bus4.instr_count !== e.ins[3:0]);
         if (bad) begin
            n_err = n_err + 1;
            $display("FAIL vec%0d @%0t: got st=%0d act=%0b ret=%0b cyc=%0d ins=%0d nst=%0d ncyc=%0d nins=%0d, want st=%0d act=%0b ret=%0b cyc=%0d ins=%0d ncyc=%0d nins=%0d",
                     n_vec, $time, bus.state, bus.active, bus.retire,
                     bus.cycle_count, bus.instr_count, bus4.state,
                     bus4.cycle_count, bus4.instr_count, e.st, e.act, e.ret,
                     e.cyc, e.ins, e.cyc[3:0], e.ins[3:0]);
         end
      end
   end

   // Drive inputs for this cycle, queue this cycle's expected outputs,
   // then advance to just after the next rising edge.
   task automatic step(input logic rst, input logic wr, input logic ma,
                       input logic jz, input logic [2:0] st, input logic act,
                       input logic ret, input int cyc, input int ins);
      exp_t e;
      rst_n             = rst;
      bus.waitrequest   = wr;
      bus.mem_access    = ma;
      bus.jump_to_zero  = jz;
      bus4.waitrequest  = wr;
      bus4.mem_access   = ma;
      bus4.jump_to_zero = jz;
      e.st  = st;
      e.act = act;
      e.ret = ret;
      e.cyc = cyc;
      e.ins = ins;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.waitrequest   = 1'b0;
      bus.mem_access    = 1'b0;
      bus.jump_to_zero  = 1'b0;
      bus4.waitrequest  = 1'b0;
      bus4.mem_access   = 1'b0;
      bus4.jump_to_zero = 1'b0;
      @(posedge clk);
      #1;

      //   rst wr ma jz  st act ret cyc ins
      step(0, 0, 0, 0,  0, 0, 0,  0, 0);   // held in reset
      step(1, 0, 0, 0,  0, 0, 0,  0, 0);   // IDLE after release
      // Plain instruction, no wait-states
      step(1, 0, 0, 0,  1, 1, 0,  0, 0);
      step(1, 0, 0, 0,  2, 1, 0,  1, 0);
      step(1, 0, 0, 0,  3, 1, 0,  2, 0);
      step(1, 0, 0, 0,  4, 1, 0,  3, 0);
      // FETCH held by 3 wait-states
      step(1, 1, 0, 0,  1, 1, 1,  4, 1);
      step(1, 1, 0, 0,  1, 1, 0,  5, 1);
      step(1, 1, 0, 0,  1, 1, 0,  6, 1);
      step(1, 0, 0, 0,  1, 1, 0,  7, 1);
      step(1, 1, 1, 1,  2, 1, 0,  8, 1);   // DECODE ignores inputs
      step(1, 1, 0, 0,  3, 1, 0,  9, 1);   // waitrequest without mem_access
      step(1, 1, 0, 0,  4, 1, 0, 10, 1);
      // EXEC1 stalled 2 cycles, EXEC2 stalled 1 cycle with jz ignored
      step(1, 0, 0, 0,  1, 1, 1, 11, 2);
      step(1, 0, 0, 0,  2, 1, 0, 12, 2);
      step(1, 1, 1, 0,  3, 1, 0, 13, 2);
      step(1, 1, 1, 0,  3, 1, 0, 14, 2);
      step(1, 0, 1, 0,  3, 1, 0, 15, 2);
      step(1, 1, 1, 1,  4, 1, 0, 16, 2);
      step(1, 0, 1, 0,  4, 1, 0, 17, 2);
      // Jump to zero halts the core
      step(1, 0, 0, 0,  1, 1, 1, 18, 3);
      step(1, 0, 0, 1,  2, 1, 0, 19, 3);
      step(1, 0, 0, 1,  3, 1, 0, 20, 3);
      step(1, 0, 0, 1,  4, 1, 0, 21, 3);
      step(1, 1, 1, 1,  7, 0, 1, 22, 4);
      for (int i = 0; i < 10; i++) begin
         step(1, logic'(i[0]), 1, logic'(i[1]), 7, 0, 0, 22, 4);
      end
      // Reset from HALTED, then async reset in the middle of a stalled EXEC1
      step(0, 0, 0, 0,  0, 0, 0,  0, 0);
      step(1, 0, 0, 0,  0, 0, 0,  0, 0);
      step(1, 0, 0, 0,  1, 1, 0,  0, 0);
      step(1, 0, 0, 0,  2, 1, 0,  1, 0);
      step(1, 1, 1, 0,  3, 1, 0,  2, 0);
      step(0, 1, 1, 0,  0, 0, 0,  0, 0);
      step(1, 0, 0, 0,  0, 0, 0,  0, 0);
      step(1, 0, 0, 0,  1, 1, 0,  0, 0);
      step(1, 0, 0, 0,  2, 1, 0,  1, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (q.size() > 0) begin
         n_vec = n_vec + 1;
         n_err = n_err + 1;
         $display("FAIL drain: %0d expected records left, want 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
